reg_file_mp: RTL and testbench

Parametrised multi-port register file for the ARM pipeline's decode and write-back stages. It provides a configurable number of asynchronous read ports and two prioritised synchronous write ports: write-back, plus a second port for base-register update or load/store writeback. Same-cycle write-to-read bypass replaces a split-clock write scheme. A sequential initialisation engine loads reset values one register per cycle and signals readiness to the pipeline.

---
 rtl/reg_file_mp.sv | 146 ++++++++++++++
 tb/tb_reg_file_mp.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port register file for the decode / write-back stages.
// Asynchronous read ports, two prioritised synchronous write ports
// (wr1 beats wr0), optional same-cycle write-to-read bypass, and a
// sequential initialisation engine that loads one register per cycle
// and raises 'ready' once every register has been written.
//
// Write handshake: a write is accepted on every rising edge where
// wrN_en is high, rst is low and the engine is in RUN; there is no
// back-pressure, so the pipeline must hold off until 'ready' is high.
module reg_file_mp #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int NUM_REGS   = 15,
  parameter int RD_PORTS   = 3,
  parameter int RESET_MODE = 0,
  parameter int BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr0_en,
  input  logic [ADDR_W-1:0]            wr0_addr,
  input  logic [DATA_W-1:0]            wr0_data,
  input  logic                         wr1_en,
  input  logic [ADDR_W-1:0]            wr1_addr,
  input  logic [DATA_W-1:0]            wr1_data,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data,
  output logic                         ready,
  output logic                         err_oor
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  // One extra bit so NUM_REGS == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   init_idx_q, init_idx_d;
  logic                ready_q, ready_d;
  logic                err_oor_q, err_oor_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];

  logic                wr0_in_range, wr1_in_range;
  logic                wr0_live, wr1_live;
  logic [DATA_W-1:0]   init_val;
  logic [RD_PORTS*DATA_W-1:0] rd_data_c;

  assign wr0_in_range = ({1'b0, wr0_addr} < NUM_REGS_W);
  assign wr1_in_range = ({1'b0, wr1_addr} < NUM_REGS_W);

  // Writes only take effect in RUN, so ports are dead during init.
  assign wr0_live = (state_q == ST_RUN) && wr0_en && wr0_in_range;
  assign wr1_live = (state_q == ST_RUN) && wr1_en && wr1_in_range;

  // Index value zero-extended (or truncated when DATA_W < ADDR_W).
  assign init_val = (RESET_MODE == 0) ? DATA_W'(init_idx_q) : '0;

  // Next-state logic for the init engine and the sticky error flag.
  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    ready_d    = ready_q;
    err_oor_d  = err_oor_q;
    if (state_q == ST_INIT) begin
      if (init_idx_q == LAST_IDX) begin
        state_d = ST_RUN;
        ready_d = 1'b1;
      end else begin
        init_idx_d = init_idx_q + 1'b1;
      end
    end else begin
      if ((wr0_en && !wr0_in_range) || (wr1_en && !wr1_in_range)) begin
        err_oor_d = 1'b1;
      end
    end
  end

  // Control state: synchronous reset restarts initialisation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
      ready_q    <= 1'b0;
      err_oor_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      ready_q    <= ready_d;
      err_oor_q  <= err_oor_d;
    end
  end

  // Array next value: init load, or wr0 then wr1 so wr1 wins a collision.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (state_q == ST_INIT) begin
          if (init_idx_q == ADDR_W'(i)) regs_d[i] = init_val;
        end else begin
          if (wr0_live && (wr0_addr == ADDR_W'(i))) regs_d[i] = wr0_data;
          if (wr1_live && (wr1_addr == ADDR_W'(i))) regs_d[i] = wr1_data;
        end
      end
    end
  end

  // Array storage; rst does not clear it, the init engine rewrites it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_q[i] <= regs_d[i];
    end
  end

  // Read ports: zero during init and for out-of-range addresses,
  // otherwise stored value optionally overridden by same-cycle writes.
  always_comb begin
    rd_data_c = '0;
    if (state_q == ST_RUN) begin
      for (int k = 0; k < RD_PORTS; k++) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (rd_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(i)) begin
            rd_data_c[k*DATA_W +: DATA_W] = regs_q[i];
          end
        end
        if (BYPASS != 0) begin
          if (wr0_live && (wr0_addr == rd_addr[k*ADDR_W +: ADDR_W])) begin
            rd_data_c[k*DATA_W +: DATA_W] = wr0_data;
          end
          if (wr1_live && (wr1_addr == rd_addr[k*ADDR_W +: ADDR_W])) begin
            rd_data_c[k*DATA_W +: DATA_W] = wr1_data;
          end
        end
      end
    end
  end

  assign rd_data = rd_data_c;
  assign ready   = ready_q;
  assign err_oor = err_oor_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp. Two instances share all inputs:
// dut_a uses defaults (index reset values, bypass on), dut_b uses
// zero reset values with bypass off.
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int RP = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               wr0_en, wr1_en;
  logic [AW-1:0]      wr0_addr, wr1_addr;
  logic [DW-1:0]      wr0_data, wr1_data;
  logic [RP*AW-1:0]   rd_addr;
  logic [RP*DW-1:0]   rd_data_a, rd_data_b;
  logic               ready_a, ready_b, err_a, err_b;

  int total = 0;
  int bad   = 0;

  // clock / reset block
  always #5 clk = ~clk;

  reg_file_mp dut_a (
    .clk(clk), .rst(rst),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_addr(rd_addr), .rd_data(rd_data_a),
    .ready(ready_a), .err_oor(err_a)
  );

  reg_file_mp #(.RESET_MODE(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .rd_addr(rd_addr), .rd_data(rd_data_b),
    .ready(ready_b), .err_oor(err_b)
  );

  task automatic chk(input string tag, input logic [RP*DW-1:0] obs,
                     input logic [RP*DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2);
    rd_addr = {a2, a1, a0};
    #1;
  endtask

  task automatic wr0(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr0_en = en; wr0_addr = a; wr0_data = d;
  endtask

  task automatic wr1(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr1_en = en; wr1_addr = a; wr1_data = d;
  endtask

  function automatic logic [RP*DW-1:0] rd3(input logic [DW-1:0] d0,
      input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    return {d2, d1, d0};
  endfunction

  // Runs the init phase with rst low, checking ready on every edge.
  task automatic run_init(input string tag);
    for (int i = 1; i <= 15; i++) begin
      chk({tag, "_rd_zero_a"}, rd_data_a, '0);
      tick();
      chk({tag, "_ready_a"}, {95'd0, ready_a}, {95'd0, (i == 15)});
      chk({tag, "_ready_b"}, {95'd0, ready_b}, {95'd0, (i == 15)});
    end
  endtask

  initial begin
    rst = 1'b1;
    wr0(1'b0, '0, '0);
    wr1(1'b0, '0, '0);
    rd_addr = {4'd0, 4'd2, 4'd7};

    // reset state
    tick();
    chk("rst_ready_a", {95'd0, ready_a}, '0);
    chk("rst_err_a", {95'd0, err_a}, '0);
    chk("rst_rd_a", rd_data_a, '0);
    chk("rst_rd_b", rd_data_b, '0);

    // initialisation
    rst = 1'b0;
    run_init("init1");
    set_rd(4'd7, 4'd2, 4'd0);
    chk("init_vals_a", rd_data_a, rd3(32'd7, 32'd2, 32'd0));
    chk("init_vals_b", rd_data_b, '0);

    // write-back bypass
    wr0(1'b1, 4'd3, 32'hDEADBEEF);
    set_rd(4'd3, 4'd3, 4'd0);
    chk("byp_a", rd_data_a, rd3(32'hDEADBEEF, 32'hDEADBEEF, 32'd0));
    chk("byp_b", rd_data_b, '0);
    tick();
    wr0(1'b0, '0, '0);
    #1;
    chk("byp_next_a", rd_data_a, rd3(32'hDEADBEEF, 32'hDEADBEEF, 32'd0));
    chk("byp_next_b", rd_data_b, rd3(32'hDEADBEEF, 32'hDEADBEEF, 32'd0));

    // dual-write collision
    wr0(1'b1, 4'd5, 32'h11111111);
    wr1(1'b1, 4'd5, 32'h22222222);
    set_rd(4'd5, 4'd3, 4'd4);
    chk("coll_byp_a", rd_data_a, rd3(32'h22222222, 32'hDEADBEEF, 32'd4));
    chk("coll_byp_b", rd_data_b, rd3(32'd0, 32'hDEADBEEF, 32'd0));
    tick();
    wr0(1'b0, '0, '0);
    wr1(1'b0, '0, '0);
    #1;
    chk("coll_stored_a", rd_data_a, rd3(32'h22222222, 32'hDEADBEEF, 32'd4));
    chk("coll_stored_b", rd_data_b, rd3(32'h22222222, 32'hDEADBEEF, 32'd0));

    // distinct writes on both ports the same cycle
    wr0(1'b1, 4'd6, 32'h0000_6666);
    wr1(1'b1, 4'd8, 32'h0000_8888);
    set_rd(4'd6, 4'd8, 4'd10);
    chk("dual_byp_a", rd_data_a, rd3(32'h6666, 32'h8888, 32'd10));
    tick();
    wr0(1'b0, '0, '0);
    wr1(1'b0, '0, '0);
    #1;
    chk("dual_stored_b", rd_data_b, rd3(32'h6666, 32'h8888, 32'd0));

    // out-of-range write
    wr0(1'b1, 4'd15, 32'h12345678);
    set_rd(4'd15, 4'd14, 4'd3);
    chk("oor_byp_a", rd_data_a, rd3(32'd0, 32'd14, 32'hDEADBEEF));
    chk("oor_err_pre", {95'd0, err_a}, '0);
    tick();
    wr0(1'b0, '0, '0);
    #1;
    chk("oor_err_a", {95'd0, err_a}, {95'd0, 1'b1});
    chk("oor_err_b", {95'd0, err_b}, {95'd0, 1'b1});
    chk("oor_unchanged_a", rd_data_a, rd3(32'd0, 32'd14, 32'hDEADBEEF));
    chk("oor_unchanged_b", rd_data_b, rd3(32'd0, 32'd0, 32'hDEADBEEF));
    set_rd(4'd0, 4'd1, 4'd2);
    chk("oor_low_a", rd_data_a, rd3(32'd0, 32'd1, 32'd2));
    tick();
    tick();
    chk("oor_sticky_a", {95'd0, err_a}, {95'd0, 1'b1});

    // three aliased read ports with a wr1 bypass
    wr1(1'b1, 4'd9, 32'hA5A5A5A5);
    set_rd(4'd9, 4'd9, 4'd9);
    chk("alias_byp_a", rd_data_a, rd3(32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5));
    chk("alias_byp_b", rd_data_b, '0);
    tick();
    wr1(1'b0, '0, '0);
    #1;
    chk("alias_stored_b", rd_data_b, rd3(32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5));

    // reset mid-RUN, with a write on the reset edge that must be dropped
    wr0(1'b1, 4'd2, 32'hCAFE0000);
    tick();
    wr0(1'b0, '0, '0);
    set_rd(4'd2, 4'd4, 4'd9);
    chk("r2_cafe_a", rd_data_a, rd3(32'hCAFE0000, 32'd4, 32'hA5A5A5A5));
    rst = 1'b1;
    wr0(1'b1, 4'd4, 32'hFFFF0000);
    tick();
    rst = 1'b0;
    wr0(1'b0, '0, '0);
    #1;
    chk("rrun_ready_a", {95'd0, ready_a}, '0);
    chk("rrun_err_a", {95'd0, err_a}, '0);
    chk("rrun_rd_b", rd_data_b, '0);
    run_init("init2");
    chk("rrun_vals_a", rd_data_a, rd3(32'd2, 32'd4, 32'd9));
    chk("rrun_vals_b", rd_data_b, '0);
    chk("rrun_err_after_a", {95'd0, err_a}, '0);

    // reset mid-INIT at index 8, with writes driven during init
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("rinit_ready_a", {95'd0, ready_a}, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr0(1'b1, 4'd2, 32'h00000BAD);
    wr1(1'b1, 4'd15, 32'h00000BAD);
    run_init("init3");
    wr0(1'b0, '0, '0);
    wr1(1'b0, '0, '0);
    #1;
    set_rd(4'd2, 4'd14, 4'd13);
    chk("rinit_vals_a", rd_data_a, rd3(32'd2, 32'd14, 32'd13));
    chk("rinit_vals_b", rd_data_b, '0);
    chk("rinit_err_a", {95'd0, err_a}, '0);
    chk("rinit_err_b", {95'd0, err_b}, '0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
